// File: rtl/seq_det_ctrl.sv
// Frame controller around a serial 1011 detector: loads a parallel frame, shifts it
// MSB-first through the detector, pulses PO per match and reports a saturating count.
module seq_det_ctrl #(
    parameter int FRAME_W = 8,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] din,
    input  logic               overlap,
    input  logic               chain,
    output logic               busy,
    output logic               PO,
    output logic               done,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int IDX_W = $clog2(FRAME_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

    ctrl_t              ctrl_reg, ctrl_next;
    det_t               det_reg, det_next;
    logic [FRAME_W-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               ovl_reg, ovl_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               po_reg, po_next;
    logic               bit_in;
    logic               match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_reg  <= IDLE;
            det_reg   <= S0;
            shift_reg <= '0;
            idx_reg   <= '0;
            ovl_reg   <= 1'b0;
            cnt_reg   <= '0;
            po_reg    <= 1'b0;
        end else begin
            ctrl_reg  <= ctrl_next;
            det_reg   <= det_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            ovl_reg   <= ovl_next;
            cnt_reg   <= cnt_next;
            po_reg    <= po_next;
        end
    end

    always_comb begin
        ctrl_next  = ctrl_reg;
        det_next   = det_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        ovl_next   = ovl_reg;
        cnt_next   = cnt_reg;
        po_next    = 1'b0;
        match      = 1'b0;
        bit_in     = shift_reg[FRAME_W-1];

        case (ctrl_reg)
            IDLE: begin
                if (start) begin
                    shift_next = din;
                    ovl_next   = overlap;
                    cnt_next   = '0;
                    idx_next   = '0;
                    // Chaining keeps the partial prefix from the previous frame
                    if (!chain) det_next = S0;
                    ctrl_next  = SHIFT;
                end
            end
            SHIFT: begin
                shift_next = {shift_reg[FRAME_W-2:0], 1'b0};
                idx_next   = idx_reg + 1'b1;
                case (det_reg)
                    S0: det_next = bit_in ? S1 : S0;
                    S1: det_next = bit_in ? S1 : S2;
                    S2: det_next = bit_in ? S3 : S0;
                    S3: begin
                        if (bit_in) begin
                            match    = 1'b1;
                            det_next = ovl_reg ? S1 : S0;
                        end else begin
                            det_next = S2;
                        end
                    end
                    default: det_next = S0;
                endcase
                if (match) begin
                    po_next = 1'b1;
                    if (cnt_reg != {CNT_W{1'b1}}) cnt_next = cnt_reg + 1'b1;
                end
                if (idx_reg == LAST_IDX) ctrl_next = DONE;
            end
            DONE: ctrl_next = IDLE;
            default: ctrl_next = IDLE;
        endcase
    end

    assign busy      = (ctrl_reg != IDLE);
    assign done      = (ctrl_reg == DONE);
    assign PO        = po_reg;
    assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: a sliding-window model of the 1011 search checks every cycle,
// and per-frame literal expectations pin PO/busy/done timing and final counts.
module tb_seq_det_ctrl;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          overlap = 1'b0;
    logic          chain = 1'b0;
    logic [FW-1:0] din = '0;

    logic       busy, po, done;
    logic [3:0] cnt;
    logic       busy1, po1, done1;
    logic [0:0] cnt1;

    int total = 0;
    int bad = 0;
    logic cmp_en = 1'b0;

    seq_det_ctrl #(.FRAME_W(FW), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .din(din), .overlap(overlap),
        .chain(chain), .busy(busy), .PO(po), .done(done), .match_cnt(cnt)
    );

    seq_det_ctrl #(.FRAME_W(FW), .CNT_W(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .din(din), .overlap(overlap),
        .chain(chain), .busy(busy1), .PO(po1), .done(done1), .match_cnt(cnt1)
    );

    always #5 clk = ~clk;

    // Model: the detector matches when the last four consumed bits are 1011; the
    // window forgets its history on an unchained start and, when not overlapping, on a match.
    int            m_phase = 0;
    logic [FW-1:0] m_data = '0;
    logic          m_ovl = 1'b0;
    logic [3:0]    m_hist = '0;
    int            m_hlen = 0;
    int            m_cnt = 0;
    int            m_cnt1 = 0;
    logic          m_po = 1'b0;

    always @(posedge clk or posedge reset) begin
        logic [3:0] h;
        int         l, c, c1;
        logic       p;
        if (reset) begin
            m_phase <= 0; m_data <= '0; m_ovl <= 1'b0; m_hist <= '0;
            m_hlen <= 0; m_cnt <= 0; m_cnt1 <= 0; m_po <= 1'b0;
        end else begin
            h = m_hist; l = m_hlen; c = m_cnt; c1 = m_cnt1; p = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    m_data  <= din;
                    m_ovl   <= overlap;
                    c = 0; c1 = 0;
                    if (!chain) l = 0;
                    m_phase <= 1;
                end
            end else if (m_phase <= FW) begin
                h = {h[2:0], m_data[FW-m_phase]};
                if (l < 4) l = l + 1;
                if (l == 4 && h == 4'b1011) begin
                    p = 1'b1;
                    if (c < 15) c = c + 1;
                    if (c1 < 1) c1 = c1 + 1;
                    if (!m_ovl) l = 0;
                end
                m_phase <= m_phase + 1;
            end else begin
                m_phase <= 0;
            end
            m_hist <= h; m_hlen <= l; m_cnt <= c; m_cnt1 <= c1; m_po <= p;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model busy", int'(busy), int'(m_phase != 0));
            chk("model done", int'(done), int'(m_phase == FW + 1));
            chk("model po", int'(po), int'(m_po));
            chk("model cnt", int'(cnt), m_cnt);
            chk("model po1", int'(po1), int'(m_po));
            chk("model busy1", int'(busy1), int'(m_phase != 0));
            chk("model done1", int'(done1), int'(m_phase == FW + 1));
            chk("model cnt1", int'(cnt1), m_cnt1);
        end
    end

    task automatic run_frame(input string name, input logic [FW-1:0] d, input logic ov,
                             input logic ch, input int glitch_c, input logic [9:0] exp_po,
                             input int exp_cnt, input int exp_cnt1);
        logic [9:0] pm, bm, dm;
        int fc, fc1;
        pm = '0; bm = '0; dm = '0; fc = 0; fc1 = 0;
        @(negedge clk);
        start = 1'b1; din = d; overlap = ov; chain = ch;
        for (int c = 1; c <= FW + 1; c++) begin
            @(negedge clk);
            start = (c == glitch_c);
            din = (c == glitch_c) ? ~d : FW'($urandom);
            overlap = ~ov;
            chain = ~ch;
            pm[c] = po; bm[c] = busy; dm[c] = done;
            if (c == FW + 1) begin fc = int'(cnt); fc1 = int'(cnt1); end
        end
        start = 1'b0;
        chk({name, " po_mask"}, int'(pm), int'(exp_po));
        chk({name, " busy_mask"}, int'(bm), int'(10'h3FE));
        chk({name, " done_mask"}, int'(dm), int'(10'h200));
        chk({name, " cnt"}, fc, exp_cnt);
        chk({name, " cnt1"}, fc1, exp_cnt1);
        $display("frame %s din=%b ovl=%0d chain=%0d po_mask=%h cnt=%0d cnt1=%0d",
                 name, d, ov, ch, pm, fc, fc1);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset po", int'(po), 0);
        chk("reset done", int'(done), 0);
        chk("reset cnt", int'(cnt), 0);
        reset = 1'b0;

        run_frame("basic", 8'b1011_1011, 1'b0, 1'b0, 0, 10'h220, 2, 1);
        run_frame("ovl1", 8'b1011_0110, 1'b1, 1'b0, 0, 10'h120, 2, 1);
        run_frame("ovl0", 8'b1011_0110, 1'b0, 1'b0, 0, 10'h020, 1, 1);
        run_frame("pre", 8'b0000_0101, 1'b0, 1'b0, 0, 10'h000, 0, 0);
        run_frame("chain1", 8'b1000_0000, 1'b0, 1'b1, 0, 10'h004, 1, 1);
        run_frame("pre2", 8'b0000_0101, 1'b0, 1'b0, 0, 10'h000, 0, 0);
        run_frame("chain0", 8'b1000_0000, 1'b0, 1'b0, 0, 10'h000, 0, 0);
        run_frame("glitch", 8'b1011_1011, 1'b0, 1'b0, 3, 10'h220, 2, 1);

        // Abort a frame with reset during its fourth SHIFT cycle
        @(negedge clk);
        start = 1'b1; din = 8'b1011_1011; overlap = 1'b0; chain = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort po", int'(po), 0);
        chk("abort done", int'(done), 0);
        chk("abort cnt", int'(cnt), 0);
        chk("abort cnt1", int'(cnt1), 0);
        @(negedge clk);
        chk("abort no done", int'(done), 0);
        reset = 1'b0;
        $display("frame abort reset applied in SHIFT cycle 4");
        run_frame("after_abort", 8'b1011_1011, 1'b0, 1'b0, 0, 10'h220, 2, 1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
